snoop_filter_mnt_engine: RTL and testbench

- Maintenance engine for a multi-bank snoop filter tag SRAM. Performs four maintenance operations: INIT, SCAN, RD_SET and WR_SET.
- Drives the SRAM maintenance port and raises mnt_ops to block functional lookups while it works.
- Sits between the CSR/maintenance controller and the snoop filter tag arrays. Generalises the single-bank filter to NBANKS banks, configurable entry width and configurable read latency.

---
 rtl/snoop_filter_mnt_engine_if.sv | 47 ++++
 rtl/snoop_filter_mnt_engine.sv | 141 ++++++++++++++
 tb/tb_snoop_filter_mnt_engine.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/snoop_filter_mnt_engine_if.sv
// Maintenance request/response, SRAM maintenance port and status bundle
// between the CSR controller, the snoop filter maintenance engine and the
// tag SRAM banks.
interface snoop_filter_mnt_engine_if #(
    parameter int NSETS   = 64,
    parameter int NWAYS   = 4,
    parameter int ENTRY_W = 16,
    parameter int NBANKS  = 2
);
    localparam int SET_W  = $clog2(NSETS);
    localparam int ROW_W  = $clog2(NSETS / NBANKS);
    localparam int DATA_W = NWAYS * ENTRY_W;

    logic                       op_valid;
    logic                       op_ready;
    logic [1:0]                 op_code;
    logic [SET_W-1:0]           op_set;
    logic [DATA_W-1:0]          op_wdata;
    logic                       abort;
    logic                       mnt_ops;
    logic [NBANKS-1:0]          mem_cen;
    logic                       mem_wen;
    logic [ROW_W-1:0]           mem_set_index;
    logic [DATA_W-1:0]          mem_wdata;
    logic [NBANKS*DATA_W-1:0]   mem_rdata;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [SET_W-1:0]           rsp_set;
    logic [NWAYS-1:0]           rsp_vld_vec;
    logic [DATA_W-1:0]          rsp_data;
    logic                       done;
    logic                       busy;

    // Controller plus SRAM side: issues operations, returns read data.
    modport master (
        output op_valid, op_code, op_set, op_wdata, abort, rsp_ready, mem_rdata,
        input  op_ready, mnt_ops, mem_cen, mem_wen, mem_set_index, mem_wdata,
               rsp_valid, rsp_set, rsp_vld_vec, rsp_data, done, busy
    );

    // Engine side.
    modport slave (
        input  op_valid, op_code, op_set, op_wdata, abort, rsp_ready, mem_rdata,
        output op_ready, mnt_ops, mem_cen, mem_wen, mem_set_index, mem_wdata,
               rsp_valid, rsp_set, rsp_vld_vec, rsp_data, done, busy
    );
endinterface

// File: rtl/snoop_filter_mnt_engine.sv
// Snoop filter tag SRAM maintenance engine: INIT / SCAN / RD_SET / WR_SET
// over NBANKS interleaved banks (set s -> bank s%NBANKS, row s/NBANKS).
module snoop_filter_mnt_engine #(
    parameter int NSETS   = 64,
    parameter int NWAYS   = 4,
    parameter int ENTRY_W = 16,
    parameter int NBANKS  = 2,
    parameter int RD_LAT  = 1
) (
    input logic                     clk,
    input logic                     rst,
    snoop_filter_mnt_engine_if.slave bus
);
    localparam int SET_W  = $clog2(NSETS);
    localparam int ROW_W  = $clog2(NSETS / NBANKS);
    localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int DATA_W = NWAYS * ENTRY_W;
    localparam int LAT_W  = 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [1:0] OP_INIT = 2'd0;
    localparam logic [1:0] OP_SCAN = 2'd1;
    localparam logic [1:0] OP_RD   = 2'd2;
    localparam logic [1:0] OP_WR   = 2'd3;

    logic [2:0]        state, state_nxt;
    logic [1:0]        op_q;
    logic [SET_W-1:0]  set_q;
    logic [SET_W-1:0]  cnt;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic              abort_q;

    logic              multi;
    logic              is_write;
    logic              abort_seen;
    logic              last_set;
    logic              accept;
    logic              capture;
    logic [SET_W-1:0]  cur_set;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [NWAYS-1:0]  vld_vec;

    // INIT/SCAN walk the counter; RD_SET/WR_SET target the latched set.
    assign multi      = (op_q == OP_INIT) || (op_q == OP_SCAN);
    assign is_write   = (op_q == OP_INIT) || (op_q == OP_WR);
    assign abort_seen = abort_q || bus.abort;
    assign last_set   = (cnt == SET_W'(NSETS - 1));
    assign accept     = (state == S_IDLE) && bus.op_valid;
    assign capture    = (state == S_WAIT) && (lat_cnt == LAT_W'(RD_LAT));
    assign cur_set    = multi ? cnt : set_q;
    assign bank       = BANK_W'(cur_set % NBANKS);
    assign row        = ROW_W'(cur_set / NBANKS);

    // The entry MSB is its valid bit.
    genvar w;
    generate
        for (w = 0; w < NWAYS; w++) begin : g_vld
            assign vld_vec[w] = rdata_q[w*ENTRY_W + ENTRY_W - 1];
        end
    endgenerate

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.op_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = is_write ? S_NEXT : S_WAIT;
            S_WAIT:  if (capture) state_nxt = S_EVAL;
            S_EVAL:  state_nxt = ((op_q == OP_RD) || (|vld_vec)) ? S_RESP : S_NEXT;
            S_RESP:  if (bus.rsp_ready) state_nxt = S_NEXT;
            S_NEXT:  state_nxt = (!multi || last_set || abort_seen) ? S_DONE : S_ISSUE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Request latch and set counter; counter stops at the last set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_INIT;
            set_q   <= '0;
            wdata_q <= '0;
            cnt     <= '0;
        end else if (accept) begin
            op_q    <= bus.op_code;
            set_q   <= bus.op_set;
            wdata_q <= bus.op_wdata;
            cnt     <= '0;
        end else if (state == S_NEXT && multi && !last_set && !abort_seen) begin
            cnt     <= cnt + 1'b1;
        end
    end

    // Read latency counter; the bank slice is sampled RD_LAT cycles after ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0;
            rdata_q <= '0;
        end else begin
            if (state == S_ISSUE)     lat_cnt <= LAT_W'(1);
            else if (state == S_WAIT) lat_cnt <= lat_cnt + 1'b1;
            if (capture) rdata_q <= bus.mem_rdata[bank*DATA_W +: DATA_W];
        end
    end

    // Sticky abort for the walking operations; cleared on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          abort_q <= 1'b0;
        else if (state == S_IDLE || state == S_DONE)      abort_q <= 1'b0;
        else if (bus.abort && multi)                      abort_q <= 1'b1;
    end

    assign bus.op_ready      = (state == S_IDLE);
    assign bus.busy          = (state != S_IDLE);
    assign bus.mnt_ops       = (state != S_IDLE) && (state != S_DONE);
    assign bus.done          = (state == S_DONE);
    assign bus.mem_cen       = (state == S_ISSUE) ? (NBANKS'(1) << bank) : '0;
    assign bus.mem_wen       = (state == S_ISSUE) && is_write;
    assign bus.mem_set_index = (state == S_ISSUE) ? row : '0;
    assign bus.mem_wdata     = (state == S_ISSUE && op_q == OP_WR) ? wdata_q : '0;
    assign bus.rsp_valid     = (state == S_RESP);
    assign bus.rsp_set       = cur_set;
    assign bus.rsp_data      = rdata_q;
    assign bus.rsp_vld_vec   = vld_vec;
endmodule

// File: tb/tb_snoop_filter_mnt_engine.sv
// Directed bench for snoop_filter_mnt_engine: RD_LAT=1 instance with a
// behavioural banked SRAM, plus an RD_LAT=3 instance fed directly.
module tb_snoop_filter_mnt_engine;
    localparam int NSETS = 64, NWAYS = 4, ENTRY_W = 16, NBANKS = 2;
    localparam int SET_W = 6, ROW_W = 5, DATA_W = NWAYS * ENTRY_W, ROWS = NSETS / NBANKS;
    localparam logic [1:0] OP_INIT = 2'd0, OP_SCAN = 2'd1, OP_RD = 2'd2, OP_WR = 2'd3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    snoop_filter_mnt_engine_if #(.NSETS(NSETS), .NWAYS(NWAYS), .ENTRY_W(ENTRY_W), .NBANKS(NBANKS)) bus ();
    snoop_filter_mnt_engine_if #(.NSETS(NSETS), .NWAYS(NWAYS), .ENTRY_W(ENTRY_W), .NBANKS(NBANKS)) bus3 ();

    snoop_filter_mnt_engine #(.NSETS(NSETS), .NWAYS(NWAYS), .ENTRY_W(ENTRY_W), .NBANKS(NBANKS), .RD_LAT(1))
        dut (.clk(clk), .rst(rst), .bus(bus));
    snoop_filter_mnt_engine #(.NSETS(NSETS), .NWAYS(NWAYS), .ENTRY_W(ENTRY_W), .NBANKS(NBANKS), .RD_LAT(3))
        dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // Banked SRAM with one-cycle read latency.
    logic [DATA_W-1:0] mem [NBANKS][ROWS];
    logic [NBANKS-1:0][DATA_W-1:0] rd_q;
    always @(posedge clk) begin
        for (int b = 0; b < NBANKS; b++)
            if (bus.mem_cen[b]) begin
                if (bus.mem_wen) mem[b][bus.mem_set_index] <= bus.mem_wdata;
                else             rd_q[b] <= mem[b][bus.mem_set_index];
            end
    end
    assign bus.mem_rdata = rd_q;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_op(input logic [1:0] code, input logic [SET_W-1:0] s, input logic [DATA_W-1:0] wd);
        bus.op_code = code; bus.op_set = s; bus.op_wdata = wd; bus.op_valid = 1'b1;
        tick();
        bus.op_valid = 1'b0;
    endtask

    // Returns the cycle (0 = first cycle after acceptance) at which done is seen.
    task automatic wait_done(input int max, output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        while (cyc < max && !ok) begin
            if (bus.done) ok = 1'b1;
            else begin tick(); cyc++; end
        end
        if (ok) tick();
    endtask

    task automatic prep_op(input logic [1:0] code, input int s, input logic [DATA_W-1:0] wd);
        int c; bit ok;
        start_op(code, SET_W'(s), wd);
        wait_done(400, c, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL prep_done: op %0d set %0d no done within %0d cycles", code, s, c); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL rst_op_ready: got %b exp 1", bus.op_ready); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
        n_checks++; if (bus.mnt_ops !== 1'b0) begin n_fail++; $display("FAIL rst_mnt_ops: got %b exp 0", bus.mnt_ops); end
        n_checks++; if (bus.mem_cen !== 2'b00 || bus.mem_wen !== 1'b0) begin n_fail++; $display("FAIL rst_mem: cen %b wen %b exp 00/0", bus.mem_cen, bus.mem_wen); end
        n_checks++; if (bus.done !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_done_rsp: done %b rsp_valid %b exp 0/0", bus.done, bus.rsp_valid); end
        n_checks++; if (bus.rsp_data !== 64'h0 || bus.rsp_set !== 6'd0) begin n_fail++; $display("FAIL rst_rsp_fields: data %h set %0d exp 0/0", bus.rsp_data, bus.rsp_set); end
        n_checks++; if (bus3.op_ready !== 1'b1) begin n_fail++; $display("FAIL rst_op_ready3: got %b exp 1", bus3.op_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_init();
        int c, nwr, bad, mnt_bad; bit seen; logic mnt_at_done;
        start_op(OP_INIT, '0, '0);
        c = 0; nwr = 0; bad = 0; mnt_bad = 0; seen = 1'b0; mnt_at_done = 1'bx;
        while (c < 300 && !seen) begin
            if (bus.done) begin seen = 1'b1; mnt_at_done = bus.mnt_ops; end
            else begin
                if (bus.mnt_ops !== 1'b1) mnt_bad++;
                if (bus.mem_cen != 0) begin
                    if (bus.mem_cen !== (NBANKS'(1) << (nwr % NBANKS)) || bus.mem_set_index !== ROW_W'(nwr / NBANKS) ||
                        bus.mem_wen !== 1'b1 || bus.mem_wdata !== 64'h0) bad++;
                    nwr++;
                end
                tick(); c++;
            end
        end
        n_checks++; if (!seen || c != 128) begin n_fail++; $display("FAIL init_done_cycle: seen %b at %0d exp 128", seen, c); end
        n_checks++; if (nwr != 64) begin n_fail++; $display("FAIL init_writes: got %0d exp 64", nwr); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL init_pattern: %0d bad writes exp 0", bad); end
        n_checks++; if (mnt_bad != 0) begin n_fail++; $display("FAIL init_mnt_ops: %0d low cycles exp 0", mnt_bad); end
        n_checks++; if (mnt_at_done !== 1'b0) begin n_fail++; $display("FAIL init_mnt_at_done: got %b exp 0", mnt_at_done); end
        tick();
        n_checks++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL init_op_ready: got %b exp 1", bus.op_ready); end
    endtask

    task automatic test_wr_rd();
        logic [DATA_W-1:0] wd; int c; bit ok;
        wd = 64'h0000_8123_0000_0000;
        start_op(OP_WR, 6'd5, wd);
        n_checks++; if (bus.mem_cen !== 2'b10 || bus.mem_set_index !== 5'd2 || bus.mem_wen !== 1'b1 || bus.mem_wdata !== wd) begin
            n_fail++; $display("FAIL wr_issue: cen %b idx %0d wen %b wdata %h exp 10/2/1/%h", bus.mem_cen, bus.mem_set_index, bus.mem_wen, bus.mem_wdata, wd); end
        n_checks++; if (bus.busy !== 1'b1 || bus.mnt_ops !== 1'b1) begin n_fail++; $display("FAIL wr_busy: busy %b mnt %b exp 1/1", bus.busy, bus.mnt_ops); end
        wait_done(20, c, ok);
        n_checks++; if (!ok || c != 2) begin n_fail++; $display("FAIL wr_done: ok %b cycle %0d exp 2", ok, c); end
        n_checks++; if (mem[1][2] !== wd) begin n_fail++; $display("FAIL wr_sram: bank1 row2 %h exp %h", mem[1][2], wd); end
        start_op(OP_RD, 6'd5, '0);
        n_checks++; if (bus.mem_cen !== 2'b10 || bus.mem_set_index !== 5'd2 || bus.mem_wen !== 1'b0) begin
            n_fail++; $display("FAIL rd_issue: cen %b idx %0d wen %b exp 10/2/0", bus.mem_cen, bus.mem_set_index, bus.mem_wen); end
        c = 0;
        while (c < 20 && bus.rsp_valid !== 1'b1) begin tick(); c++; end
        n_checks++; if (c != 3) begin n_fail++; $display("FAIL rd_rsp_cycle: got %0d exp 3", c); end
        n_checks++; if (bus.rsp_set !== 6'd5) begin n_fail++; $display("FAIL rd_rsp_set: got %0d exp 5", bus.rsp_set); end
        n_checks++; if (bus.rsp_vld_vec !== 4'b0100) begin n_fail++; $display("FAIL rd_rsp_vld: got %b exp 0100", bus.rsp_vld_vec); end
        n_checks++; if (bus.rsp_data !== wd) begin n_fail++; $display("FAIL rd_rsp_data: got %h exp %h", bus.rsp_data, wd); end
        wait_done(20, c, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rd_done: not seen within %0d cycles", c); end
    endtask

    task automatic test_scan();
        int c, nr; logic [SET_W-1:0] rs [8]; logic [DATA_W-1:0] rdat [8];
        prep_op(OP_INIT, 0, '0);
        prep_op(OP_WR, 0, 64'h0000_0000_0000_8001);
        prep_op(OP_WR, 33, 64'h8033_0000_0000_0000);
        prep_op(OP_WR, 63, 64'h0000_0000_803F_0000);
        start_op(OP_SCAN, '0, '0);
        c = 0; nr = 0;
        while (c < 1000 && bus.done !== 1'b1) begin
            if (bus.rsp_valid && bus.rsp_ready && nr < 8) begin rs[nr] = bus.rsp_set; rdat[nr] = bus.rsp_data; nr++; end
            tick(); c++;
        end
        n_checks++; if (c != 259) begin n_fail++; $display("FAIL scan_cycles: done at %0d exp 259", c); end
        n_checks++; if (nr != 3) begin n_fail++; $display("FAIL scan_count: got %0d exp 3", nr); end
        if (nr == 3) begin
            n_checks++; if (rs[0] !== 6'd0 || rs[1] !== 6'd33 || rs[2] !== 6'd63) begin
                n_fail++; $display("FAIL scan_order: got %0d,%0d,%0d exp 0,33,63", rs[0], rs[1], rs[2]); end
            n_checks++; if (rdat[1] !== 64'h8033_0000_0000_0000 || rdat[2] !== 64'h0000_0000_803F_0000) begin
                n_fail++; $display("FAIL scan_data: got %h,%h exp 8033..,..803F0000", rdat[1], rdat[2]); end
        end
        tick();
    endtask

    task automatic test_stall();
        int c, bad; bit ok; logic [SET_W-1:0] s0; logic [DATA_W-1:0] d0; logic [NWAYS-1:0] v0;
        bus.rsp_ready = 1'b0;
        start_op(OP_SCAN, '0, '0);
        c = 0;
        while (c < 50 && bus.rsp_valid !== 1'b1) begin tick(); c++; end
        s0 = bus.rsp_set; d0 = bus.rsp_data; v0 = bus.rsp_vld_vec;
        n_checks++; if (s0 !== 6'd0 || d0 !== 64'h8001 || v0 !== 4'b0001) begin
            n_fail++; $display("FAIL stall_first: set %0d data %h vld %b exp 0/8001/0001", s0, d0, v0); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_set !== s0 || bus.rsp_data !== d0 ||
                bus.rsp_vld_vec !== v0 || bus.mem_cen !== 2'b00) bad++;
            tick();
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold: %0d unstable cycles exp 0", bad); end
        bus.rsp_ready = 1'b1;
        wait_done(1000, c, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_done: not seen within %0d cycles", c); end
    endtask

    task automatic test_abort();
        int c, nr, extra; bit aborted; logic [SET_W-1:0] rs [8];
        prep_op(OP_WR, 7, 64'h0000_0000_0000_8007);
        start_op(OP_SCAN, '0, '0);
        c = 0; nr = 0; extra = 0; aborted = 1'b0;
        while (c < 300 && bus.done !== 1'b1) begin
            if (bus.rsp_valid && bus.rsp_ready && nr < 8) begin rs[nr] = bus.rsp_set; nr++; end
            if (aborted && bus.mem_cen != 0) extra++;
            if (!aborted && bus.mem_cen == 2'b10 && bus.mem_set_index == 5'd3) begin
                tick(); c++;
                bus.abort = 1'b1; aborted = 1'b1;
                tick(); c++;
                bus.abort = 1'b0;
            end else begin
                tick(); c++;
            end
        end
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL abort_done: not seen within %0d cycles", c); end
        n_checks++; if (nr != 2 || rs[0] !== 6'd0 || rs[1] !== 6'd7) begin
            n_fail++; $display("FAIL abort_rsp: count %0d last set %0d exp 2 responses 0,7", nr, rs[nr > 0 ? nr-1 : 0]); end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL abort_extra_access: got %0d exp 0", extra); end
        tick();
        n_checks++; if (bus.op_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: ready %b busy %b exp 1/0", bus.op_ready, bus.busy); end
    endtask

    task automatic test_rst_mid();
        int c, bad; bit ok;
        start_op(OP_INIT, '0, '0);
        c = 0;
        while (c < 200 && !(bus.mem_cen == 2'b01 && bus.mem_set_index == 5'd10)) begin tick(); c++; end
        n_checks++; if (c != 40) begin n_fail++; $display("FAIL rstmid_reach: set 20 at %0d exp 40", c); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.op_ready !== 1'b1 || bus.busy !== 1'b0 || bus.mnt_ops !== 1'b0 || bus.mem_cen !== 2'b00 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: ready %b busy %b mnt %b cen %b done %b exp 1/0/0/00/0",
                bus.op_ready, bus.busy, bus.mnt_ops, bus.mem_cen, bus.done); end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_hold: %0d bad cycles exp 0", bad); end
        rst = 1'b0;
        tick();
        start_op(OP_INIT, '0, '0);
        n_checks++; if (bus.mem_cen !== 2'b01 || bus.mem_set_index !== 5'd0 || bus.mem_wen !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_restart: cen %b idx %0d wen %b exp 01/0/1", bus.mem_cen, bus.mem_set_index, bus.mem_wen); end
        wait_done(300, c, ok);
        n_checks++; if (!ok || c != 128) begin n_fail++; $display("FAIL rstmid_done: ok %b at %0d exp 128", ok, c); end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int k);
        logic [15:0] e;
        e = 16'h8A00 + 16'(k);
        pat = {e, e, e, e};
    endfunction

    task automatic test_lat3();
        int c, first;
        bus3.rsp_ready = 1'b0;
        bus3.op_code = OP_RD; bus3.op_set = 6'd5; bus3.op_valid = 1'b1;
        tick();
        bus3.op_valid = 1'b0;
        n_checks++; if (bus3.mem_cen !== 2'b10 || bus3.mem_set_index !== 5'd2) begin
            n_fail++; $display("FAIL lat3_issue: cen %b idx %0d exp 10/2", bus3.mem_cen, bus3.mem_set_index); end
        c = 0; first = -1;
        while (c < 12 && first < 0) begin
            bus3.mem_rdata = {pat(c), pat(c + 100)};
            if (bus3.rsp_valid) first = c;
            else begin tick(); c++; end
        end
        n_checks++; if (first != 5) begin n_fail++; $display("FAIL lat3_rsp_cycle: got %0d exp 5", first); end
        n_checks++; if (bus3.rsp_data !== pat(3)) begin n_fail++; $display("FAIL lat3_capture: got %h exp %h", bus3.rsp_data, pat(3)); end
        n_checks++; if (bus3.rsp_vld_vec !== 4'hF || bus3.rsp_set !== 6'd5) begin
            n_fail++; $display("FAIL lat3_fields: vld %b set %0d exp 1111/5", bus3.rsp_vld_vec, bus3.rsp_set); end
        bus3.rsp_ready = 1'b1;
        c = 0;
        while (c < 20 && bus3.done !== 1'b1) begin tick(); c++; end
        n_checks++; if (bus3.done !== 1'b1) begin n_fail++; $display("FAIL lat3_done: not seen within %0d cycles", c); end
    endtask

    initial begin
        rst = 1'b1;
        bus.op_valid = 1'b0; bus.op_code = '0; bus.op_set = '0; bus.op_wdata = '0;
        bus.abort = 1'b0; bus.rsp_ready = 1'b1;
        bus3.op_valid = 1'b0; bus3.op_code = '0; bus3.op_set = '0; bus3.op_wdata = '0;
        bus3.abort = 1'b0; bus3.rsp_ready = 1'b1; bus3.mem_rdata = '0;
        test_reset();
        test_init();
        test_wr_rd();
        test_scan();
        test_stall();
        test_abort();
        test_rst_mid();
        test_lat3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
